// File: rtl/mole_field_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mole_field_ctrl
// Purpose  : Whack-a-mole field controller. Tracks which holes hold a lit
//            mole, each with its own lifetime down-counter. It places new
//            moles on request (probing upward from a preferred hole with
//            wrap), clears moles on hits or expiry, and reports hits,
//            misses, timeouts and rejected spawns as one-cycle pulses.
// Ports    : clk_game      - game clock, all state on rising edge
//            rst           - asynchronous active-high reset
//            enable        - game running; low clears the field
//            spawn_req     - one-cycle request to place a mole
//            rand_idx      - preferred hole for the spawn
//            life_cycles   - mole lifetime in cycles (0 behaves as 1)
//            btn_hit_pulse - one debounced button pulse per hole
//            mole_led      - registered lit-hole vector
//            active_cnt    - registered popcount of mole_led
//            hit_pulse     - at least one lit mole hit
//            hit_cnt       - number of moles hit (0 when hit_pulse low)
//            miss_pulse    - a button pressed on an unlit hole
//            timeout_pulse - at least one mole expired
//            spawn_drop    - spawn_req rejected
// Revision : 1.0 - initial release
// ============================================================================
module mole_field_ctrl #(
    parameter int N_HOLES    = 5,
    parameter int MAX_ACTIVE = 2,
    parameter int LIFE_W     = 8,
    localparam int IDX_W     = $clog2(N_HOLES),
    localparam int CNT_W     = $clog2(N_HOLES + 1)
) (
    input  logic                 clk_game,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 spawn_req,
    input  logic [IDX_W-1:0]     rand_idx,
    input  logic [LIFE_W-1:0]    life_cycles,
    input  logic [N_HOLES-1:0]   btn_hit_pulse,
    output logic [N_HOLES-1:0]   mole_led,
    output logic [CNT_W-1:0]     active_cnt,
    output logic                 hit_pulse,
    output logic [CNT_W-1:0]     hit_cnt,
    output logic                 miss_pulse,
    output logic                 timeout_pulse,
    output logic                 spawn_drop
);

    // One extra bit so start + offset never overflows before the wrap.
    localparam logic [IDX_W:0] N_EXT   = (IDX_W + 1)'(N_HOLES);
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ACTIVE);

    function automatic logic [CNT_W-1:0] popcnt(input logic [N_HOLES-1:0] v);
        logic [CNT_W-1:0] c;
        c = '0;
        for (int i = 0; i < N_HOLES; i++) begin
            c = c + {{(CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic [N_HOLES-1:0] led_q,  led_d;
    logic [LIFE_W-1:0]  life_q [N_HOLES];
    logic [LIFE_W-1:0]  life_d [N_HOLES];
    logic [CNT_W-1:0]   active_q, active_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic               hit_q, hit_d;
    logic               miss_q, miss_d;
    logic               timeout_q, timeout_d;
    logic               drop_q, drop_d;

    // ------------------------------------------------------------------
    // Placement: one-hot of the first unlit hole at or above the start
    // index, wrapping to 0. Only the registered lit vector is consulted,
    // so holes freed this cycle are never candidates.
    // ------------------------------------------------------------------
    logic [IDX_W:0]     start_w;
    logic [IDX_W:0]     probe_w;
    logic [N_HOLES-1:0] pick_w;

    always_comb begin
        start_w = {1'b0, rand_idx};
        if (start_w >= N_EXT) begin
            start_w = start_w - N_EXT;
        end
        pick_w  = '0;
        probe_w = '0;
        // Walk offsets from farthest to nearest so the nearest free hole
        // is the last one written and therefore wins.
        for (int k = N_HOLES - 1; k >= 0; k--) begin
            probe_w = start_w + (IDX_W + 1)'(k);
            if (probe_w >= N_EXT) begin
                probe_w = probe_w - N_EXT;
            end
            for (int i = 0; i < N_HOLES; i++) begin
                if (((IDX_W + 1)'(i) == probe_w) && !led_q[i]) begin
                    pick_w    = '0;
                    pick_w[i] = 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state for the field and all pulse outputs.
    // ------------------------------------------------------------------
    logic [N_HOLES-1:0] hit_vec_w;
    logic [N_HOLES-1:0] expire_vec_w;
    logic               spawn_ok_w;
    logic [LIFE_W-1:0]  life_load_w;

    always_comb begin
        hit_vec_w    = btn_hit_pulse & led_q;
        expire_vec_w = '0;
        spawn_ok_w   = spawn_req && (active_q < MAX_C) && (|pick_w);
        life_load_w  = (life_cycles == '0) ? LIFE_W'(1) : life_cycles;
        led_d        = led_q;

        for (int i = 0; i < N_HOLES; i++) begin
            life_d[i] = life_q[i];
            if (hit_vec_w[i]) begin
                // A hit takes priority over expiry on the same hole.
                led_d[i]  = 1'b0;
                life_d[i] = '0;
            end else if (led_q[i]) begin
                if (life_q[i] == LIFE_W'(1)) begin
                    led_d[i]        = 1'b0;
                    life_d[i]       = '0;
                    expire_vec_w[i] = 1'b1;
                end else begin
                    life_d[i] = life_q[i] - LIFE_W'(1);
                end
            end
            // pick_w only marks currently unlit holes, so this never
            // collides with the hit/expiry handling above.
            if (spawn_ok_w && pick_w[i]) begin
                led_d[i]  = 1'b1;
                life_d[i] = life_load_w;
            end
        end

        hit_cnt_d = popcnt(hit_vec_w);
        hit_d     = |hit_vec_w;
        miss_d    = |(btn_hit_pulse & ~led_q);
        timeout_d = |expire_vec_w;
        drop_d    = spawn_req && !spawn_ok_w;

        if (!enable) begin
            led_d     = '0;
            hit_cnt_d = '0;
            hit_d     = 1'b0;
            miss_d    = 1'b0;
            timeout_d = 1'b0;
            drop_d    = 1'b0;
            for (int i = 0; i < N_HOLES; i++) begin
                life_d[i] = '0;
            end
        end

        active_d = popcnt(led_d);
    end

    always_ff @(posedge clk_game or posedge rst) begin
        if (rst) begin
            led_q     <= '0;
            active_q  <= '0;
            hit_cnt_q <= '0;
            hit_q     <= 1'b0;
            miss_q    <= 1'b0;
            timeout_q <= 1'b0;
            drop_q    <= 1'b0;
            for (int i = 0; i < N_HOLES; i++) begin
                life_q[i] <= '0;
            end
        end else begin
            led_q     <= led_d;
            active_q  <= active_d;
            hit_cnt_q <= hit_cnt_d;
            hit_q     <= hit_d;
            miss_q    <= miss_d;
            timeout_q <= timeout_d;
            drop_q    <= drop_d;
            for (int i = 0; i < N_HOLES; i++) begin
                life_q[i] <= life_d[i];
            end
        end
    end

    assign mole_led      = led_q;
    assign active_cnt    = active_q;
    assign hit_pulse     = hit_q;
    assign hit_cnt       = hit_cnt_q;
    assign miss_pulse    = miss_q;
    assign timeout_pulse = timeout_q;
    assign spawn_drop    = drop_q;

endmodule
`default_nettype wire

// File: doc/mole_field_ctrl.md
MOLE_FIELD_CTRL -- requirements
Module: mole_field_ctrl

Interface
REQ-001 Parameter N_HOLES, default 5, number of mole holes/LEDs (2..16).
REQ-002 Parameter MAX_ACTIVE, default 2, maximum simultaneously lit moles (1..N_HOLES).
REQ-003 Parameter LIFE_W, default 8, width of the per-mole lifetime counter.
REQ-004 Localparams: IDX_W = clog2(N_HOLES); CNT_W = clog2(N_HOLES+1).
REQ-005 clk_game  input  1  game clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  game running; low clears the field.
REQ-008 spawn_req  input  1  one-cycle request to place a mole.
REQ-009 rand_idx  input  IDX_W  preferred hole for the spawn.
REQ-010 life_cycles  input  LIFE_W  mole lifetime in clk_game cycles, sampled at spawn.
REQ-011 btn_hit_pulse  input  N_HOLES  one-cycle debounced button pulses, one per hole.
REQ-012 mole_led  output  N_HOLES  registered lit-hole vector.
REQ-013 active_cnt  output  CNT_W  registered popcount of mole_led.
REQ-014 hit_pulse  output  1  one-cycle pulse; at least one lit mole hit.
REQ-015 hit_cnt  output  CNT_W  number of moles hit in that cycle; 0 when hit_pulse low.
REQ-016 miss_pulse  output  1  one-cycle pulse; a button pressed on an unlit hole.
REQ-017 timeout_pulse  output  1  one-cycle pulse; at least one mole expired.
REQ-018 spawn_drop  output  1  one-cycle pulse; spawn_req rejected.

Function
REQ-019 Each hole holds a lit bit and a LIFE_W-bit down-counter; all outputs registered, one-cycle latency from inputs.
REQ-020 Pulse outputs default low every cycle unless asserted by the rules below.
REQ-021 Spawn (enable high, spawn_req high): start index s = rand_idx if rand_idx < N_HOLES, else rand_idx - N_HOLES.
REQ-022 Placement probes from s upward with wrap to 0, choosing the first hole unlit in the current registered mole_led.
REQ-023 Chosen hole lit at next edge, counter loaded with life_cycles; life_cycles = 0 loads 1.
REQ-024 Spawn rejected with spawn_drop when active_cnt == MAX_ACTIVE or no hole unlit; no state change.
REQ-025 A hole freed by hit or timeout in cycle t is not a spawn candidate in cycle t.
REQ-026 Hit: btn_hit_pulse[i] with mole_led[i] high clears hole i at next edge; hit_cnt = number of such i; hit_pulse = (hit_cnt != 0).
REQ-027 Miss: btn_hit_pulse[i] with mole_led[i] low asserts miss_pulse; no state change.
REQ-028 Lifetime: each lit counter decrements every cycle; lit hole with counter == 1 and no hit clears at next edge and asserts timeout_pulse.
REQ-029 A mole spawned with L stays lit exactly L cycles; timeout_pulse coincides with the first cycle it is dark.
REQ-030 Hit and expiry on the same hole in the same cycle: hit wins; no timeout_pulse for that hole.
REQ-031 Hits, misses, expiries and one spawn all resolve in the same cycle independently.
REQ-032 active_cnt updated at the same edge as mole_led, always equal to its popcount.
REQ-033 enable low: next edge clears all lit bits and counters, active_cnt = 0; no pulses asserted; spawn_req ignored without spawn_drop.

Reset
REQ-034 rst high asynchronously forces mole_led = 0, all counters = 0, active_cnt = 0, all pulses and hit_cnt = 0.
REQ-035 Reset mid-game discards all moles; first spawn after release behaves as from an empty field.

Verification
REQ-036 Empty field, rand_idx=3, life_cycles=4, spawn_req -> mole_led=5'b01000 for 4 cycles, then 0 with timeout_pulse=1 one cycle.
REQ-037 Hole 3 lit, spawn rand_idx=3 -> mole_led=5'b11000; third spawn (MAX_ACTIVE=2) -> spawn_drop=1, mole_led unchanged.
REQ-038 Holes 0 and 2 lit, btn_hit_pulse=5'b00111 -> next cycle mole_led=0, hit_pulse=1, hit_cnt=2, miss_pulse=1.
REQ-039 Hole 1 lit with counter=1, btn_hit_pulse[1] same cycle -> hit_pulse=1, timeout_pulse=0.
REQ-040 rand_idx=6 (N_HOLES=5), empty field -> hole 1 lit; rand_idx=4 with hole 4 lit -> hole 0 lit (wrap).
REQ-041 Two moles lit, rst pulsed high mid-cycle -> outputs 0 immediately; enable low with lit moles -> field cleared next edge, no pulses.
